// File: rtl/turn_sequencer_pkg.sv
// Shared types, constants and the squared-distance helper for the artillery turn sequencer.
package turn_sequencer_pkg;

  typedef enum logic [2:0] {
    PhAim      = 3'd0,
    PhLaunch   = 3'd1,
    PhFlight   = 3'd2,
    PhResolve  = 3'd3,
    PhSettle   = 3'd4,
    PhGameOver = 3'd5
  } phase_t;

  typedef logic player_t;

  localparam logic [3:0] ANGLE_MAX  = 4'd8;
  localparam logic [2:0] POWER_MAX  = 3'd7;
  localparam logic [3:0] ANGLE0_RST = 4'd6;
  localparam logic [3:0] ANGLE1_RST = 4'd2;
  localparam logic [2:0] POWER_RST  = 3'd3;

  // Squared Euclidean distance between two screen points; fits in 21 bits for 10-bit coordinates.
  function automatic logic [21:0] dist_sq(input logic [9:0] ax, input logic [9:0] ay,
                                          input logic [9:0] bx, input logic [9:0] by);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [21:0] sx;
    logic signed [21:0] sy;
    dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
    dy = $signed({1'b0, ay}) - $signed({1'b0, by});
    sx = 22'(dx) * 22'(dx);
    sy = 22'(dy) * 22'(dy);
    return $unsigned(sx) + $unsigned(sy);
  endfunction

endpackage

// File: rtl/turn_sequencer_key_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse (one clk wide).
module turn_sequencer_key_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q, rise_q;
  logic rise_d;

  always_comb begin
    rise_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/turn_sequencer.sv
// Two-player turn controller: aim adjust, bomb launch, hit scoring, terrain settle and turn hand-over.
module turn_sequencer
  import turn_sequencer_pkg::*;
#(
  parameter int unsigned HEALTH_INIT    = 3,
  parameter int unsigned HIT_RADIUS     = 14,
  parameter int unsigned SETTLE_FRAMES  = 2,
  parameter int unsigned FLIGHT_TIMEOUT = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_clk,
  input  logic       fire_key,
  input  logic       ang_up_key,
  input  logic       ang_dn_key,
  input  logic       pwr_up_key,
  input  logic       pwr_dn_key,
  input  logic [9:0] tank0_x,
  input  logic [9:0] tank0_y,
  input  logic [9:0] tank1_x,
  input  logic [9:0] tank1_y,
  input  logic [9:0] bomb_x,
  input  logic [9:0] bomb_y,
  input  logic       exploded,
  output logic       launch,
  output logic [9:0] launchX,
  output logic [9:0] launchY,
  output logic [3:0] angle,
  output logic [2:0] power,
  output logic       active_player,
  output logic [3:0] health0,
  output logic [3:0] health1,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] phase
);

  localparam int unsigned FlightW = $clog2(FLIGHT_TIMEOUT + 1);
  localparam int unsigned SettleW = $clog2(SETTLE_FRAMES + 1);
  localparam logic [21:0] HitR2   = 22'(HIT_RADIUS * HIT_RADIUS);
  localparam logic [3:0]  HealthI = 4'(HEALTH_INIT);

  logic frame_tick, fire_rise, ang_up_rise, ang_dn_rise, pwr_up_rise, pwr_dn_rise;

  turn_sequencer_key_edge u_frame (.clk_i(clk), .rst_i(reset), .d_i(frame_clk),
                                   .rise_o(frame_tick));
  turn_sequencer_key_edge u_fire  (.clk_i(clk), .rst_i(reset), .d_i(fire_key),
                                   .rise_o(fire_rise));
  turn_sequencer_key_edge u_ang_up(.clk_i(clk), .rst_i(reset), .d_i(ang_up_key),
                                   .rise_o(ang_up_rise));
  turn_sequencer_key_edge u_ang_dn(.clk_i(clk), .rst_i(reset), .d_i(ang_dn_key),
                                   .rise_o(ang_dn_rise));
  turn_sequencer_key_edge u_pwr_up(.clk_i(clk), .rst_i(reset), .d_i(pwr_up_key),
                                   .rise_o(pwr_up_rise));
  turn_sequencer_key_edge u_pwr_dn(.clk_i(clk), .rst_i(reset), .d_i(pwr_dn_key),
                                   .rise_o(pwr_dn_rise));

  phase_t               phase_q, phase_d;
  player_t              active_q, active_d;
  logic [3:0]           angle0_q, angle0_d, angle1_q, angle1_d;
  logic [2:0]           power0_q, power0_d, power1_q, power1_d;
  logic [3:0]           health0_q, health0_d, health1_q, health1_d;
  logic [9:0]           launch_x_q, launch_x_d, launch_y_q, launch_y_d;
  logic                 winner_q, winner_d;
  logic [FlightW-1:0]   flight_cnt_q, flight_cnt_d;
  logic [SettleW-1:0]   settle_cnt_q, settle_cnt_d;
  logic                 entry_q, entry_d;
  logic                 miss_q, miss_d;

  logic       hit0, hit1;
  logic       ang_inc, ang_dec, pwr_inc, pwr_dec;
  logic [3:0] ang_cur, ang_new;
  logic [2:0] pwr_cur, pwr_new;

  always_comb begin
    hit0 = dist_sq(bomb_x, bomb_y, tank0_x, tank0_y) <= HitR2;
    hit1 = dist_sq(bomb_x, bomb_y, tank1_x, tank1_y) <= HitR2;
  end

  // Opposing edges in the same cycle cancel; saturate at the range limits.
  always_comb begin
    ang_inc = ang_up_rise & ~ang_dn_rise;
    ang_dec = ang_dn_rise & ~ang_up_rise;
    pwr_inc = pwr_up_rise & ~pwr_dn_rise;
    pwr_dec = pwr_dn_rise & ~pwr_up_rise;
    ang_cur = active_q ? angle1_q : angle0_q;
    pwr_cur = active_q ? power1_q : power0_q;
    ang_new = ang_cur;
    pwr_new = pwr_cur;
    if (ang_inc && ang_cur != ANGLE_MAX) ang_new = ang_cur + 4'd1;
    else if (ang_dec && ang_cur != 4'd0) ang_new = ang_cur - 4'd1;
    if (pwr_inc && pwr_cur != POWER_MAX) pwr_new = pwr_cur + 3'd1;
    else if (pwr_dec && pwr_cur != 3'd0) pwr_new = pwr_cur - 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= PhAim;
      active_q     <= 1'b0;
      angle0_q     <= ANGLE0_RST;
      angle1_q     <= ANGLE1_RST;
      power0_q     <= POWER_RST;
      power1_q     <= POWER_RST;
      health0_q    <= HealthI;
      health1_q    <= HealthI;
      launch_x_q   <= '0;
      launch_y_q   <= '0;
      winner_q     <= 1'b0;
      flight_cnt_q <= '0;
      settle_cnt_q <= '0;
      entry_q      <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      active_q     <= active_d;
      angle0_q     <= angle0_d;
      angle1_q     <= angle1_d;
      power0_q     <= power0_d;
      power1_q     <= power1_d;
      health0_q    <= health0_d;
      health1_q    <= health1_d;
      launch_x_q   <= launch_x_d;
      launch_y_q   <= launch_y_d;
      winner_q     <= winner_d;
      flight_cnt_q <= flight_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      entry_q      <= entry_d;
      miss_q       <= miss_d;
    end
  end

  always_comb begin
    phase_d      = phase_q;
    active_d     = active_q;
    angle0_d     = angle0_q;
    angle1_d     = angle1_q;
    power0_d     = power0_q;
    power1_d     = power1_q;
    health0_d    = health0_q;
    health1_d    = health1_q;
    launch_x_d   = launch_x_q;
    launch_y_d   = launch_y_q;
    winner_d     = winner_q;
    flight_cnt_d = flight_cnt_q;
    settle_cnt_d = settle_cnt_q;
    entry_d      = 1'b0;
    miss_d       = miss_q;
    case (phase_q)
      PhAim: begin
        if (fire_rise) begin
          phase_d    = PhLaunch;
          launch_x_d = active_q ? tank1_x : tank0_x;
          launch_y_d = active_q ? tank1_y : tank0_y;
        end else if (active_q) begin
          angle1_d = ang_new;
          power1_d = pwr_new;
        end else begin
          angle0_d = ang_new;
          power0_d = pwr_new;
        end
      end
      PhLaunch: begin
        if (frame_tick) begin
          phase_d      = PhFlight;
          flight_cnt_d = '0;
          entry_d      = 1'b1;
        end
      end
      PhFlight: begin
        // The bomb's flag may still show the previous detonation on the entry cycle.
        if (exploded && !entry_q) begin
          phase_d = PhResolve;
          miss_d  = 1'b0;
        end else if (flight_cnt_q == FlightW'(FLIGHT_TIMEOUT)) begin
          phase_d = PhResolve;
          miss_d  = 1'b1;
        end else if (frame_tick) begin
          flight_cnt_d = flight_cnt_q + 1'b1;
        end
      end
      PhResolve: begin
        if (!miss_q) begin
          if (hit0 && health0_q != 4'd0) health0_d = health0_q - 4'd1;
          if (hit1 && health1_q != 4'd0) health1_d = health1_q - 4'd1;
        end
        phase_d      = PhSettle;
        settle_cnt_d = '0;
      end
      PhSettle: begin
        if (settle_cnt_q == SettleW'(SETTLE_FRAMES)) begin
          if (health0_q == 4'd0 || health1_q == 4'd0) begin
            phase_d  = PhGameOver;
            winner_d = (health0_q == 4'd0 && health1_q == 4'd0) ? ~active_q
                                                                : (health0_q == 4'd0);
          end else begin
            phase_d  = PhAim;
            active_d = ~active_q;
          end
        end else if (frame_tick) begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      PhGameOver: begin
        if (fire_rise) begin
          phase_d   = PhAim;
          active_d  = 1'b0;
          angle0_d  = ANGLE0_RST;
          angle1_d  = ANGLE1_RST;
          power0_d  = POWER_RST;
          power1_d  = POWER_RST;
          health0_d = HealthI;
          health1_d = HealthI;
        end
      end
      default: phase_d = PhAim;
    endcase
  end

  always_comb begin
    launch        = (phase_q == PhLaunch);
    game_over     = (phase_q == PhGameOver);
    phase         = phase_q;
    launchX       = launch_x_q;
    launchY       = launch_y_q;
    angle         = active_q ? angle1_q : angle0_q;
    power         = active_q ? power1_q : power0_q;
    active_player = active_q;
    health0       = health0_q;
    health1       = health1_q;
    winner        = winner_q;
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: aiming, launch, scoring, timeout, game over and restart.
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_clk, fire_key, ang_up_key, ang_dn_key, pwr_up_key, pwr_dn_key;
  logic [9:0] tank0_x, tank0_y, tank1_x, tank1_y, bomb_x, bomb_y;
  logic       exploded;
  logic       launch, active_player, game_over, winner;
  logic [9:0] launchX, launchY;
  logic [3:0] angle, health0, health1;
  logic [2:0] power, phase;

  int checks = 0;
  int errors = 0;

  turn_sequencer dut (
    .clk(clk), .reset(reset), .frame_clk(frame_clk), .fire_key(fire_key),
    .ang_up_key(ang_up_key), .ang_dn_key(ang_dn_key), .pwr_up_key(pwr_up_key),
    .pwr_dn_key(pwr_dn_key), .tank0_x(tank0_x), .tank0_y(tank0_y), .tank1_x(tank1_x),
    .tank1_y(tank1_y), .bomb_x(bomb_x), .bomb_y(bomb_y), .exploded(exploded),
    .launch(launch), .launchX(launchX), .launchY(launchY), .angle(angle), .power(power),
    .active_player(active_player), .health0(health0), .health1(health1),
    .game_over(game_over), .winner(winner), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mask = {fire, ang_up, ang_dn, pwr_up, pwr_dn}
  task automatic press(input logic [4:0] mask);
    {fire_key, ang_up_key, ang_dn_key, pwr_up_key, pwr_dn_key} = mask;
    cyc(4);
    {fire_key, ang_up_key, ang_dn_key, pwr_up_key, pwr_dn_key} = 5'b0;
    cyc(4);
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    cyc(4);
    frame_clk = 1'b0;
    cyc(4);
  endtask

  task automatic fire_and_detonate(input logic [9:0] bx, input logic [9:0] by);
    exploded = 1'b0;
    press(5'b10000);
    frame_pulse();
    bomb_x = bx;
    bomb_y = by;
    exploded = 1'b1;
    cyc(3);
    frame_pulse();
    frame_pulse();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    checks++; if (angle !== 4'd6) begin errors++; $display("FAIL reset_angle got %0d exp 6", angle); end
    checks++; if (power !== 3'd3) begin errors++; $display("FAIL reset_power got %0d exp 3", power); end
    checks++; if ({health0, health1} !== {4'd3, 4'd3}) begin errors++;
      $display("FAIL reset_health got %0d/%0d exp 3/3", health0, health1); end
    checks++; if ({launch, active_player, game_over, winner} !== 4'b0) begin errors++;
      $display("FAIL reset_flags got %b exp 0000", {launch, active_player, game_over, winner}); end
    checks++; if ({launchX, launchY} !== 20'd0) begin errors++;
      $display("FAIL reset_launchxy got %0d/%0d exp 0/0", launchX, launchY); end
  endtask

  task automatic test_aim_adjust();
    repeat (3) press(5'b01000);
    checks++; if (angle !== 4'd8) begin errors++; $display("FAIL angle_sat got %0d exp 8", angle); end
    press(5'b00100);
    checks++; if (angle !== 4'd7) begin errors++; $display("FAIL angle_dn got %0d exp 7", angle); end
    press(5'b01000);
    press(5'b01100);
    checks++; if (angle !== 4'd8) begin errors++; $display("FAIL angle_cancel got %0d exp 8", angle); end
    repeat (5) press(5'b00001);
    checks++; if (power !== 3'd0) begin errors++; $display("FAIL power_sat got %0d exp 0", power); end
  endtask

  task automatic test_launch();
    tank0_x = 10'd100; tank0_y = 10'd300;
    exploded = 1'b0;
    press(5'b10000);
    checks++; if ({phase, launch} !== {3'd1, 1'b1}) begin errors++;
      $display("FAIL launch_enter got phase %0d launch %b exp 1/1", phase, launch); end
    checks++; if ({launchX, launchY} !== {10'd100, 10'd300}) begin errors++;
      $display("FAIL launch_xy got %0d/%0d exp 100/300", launchX, launchY); end
    frame_clk = 1'b1;
    cyc(2);
    checks++; if (launch !== 1'b1) begin errors++; $display("FAIL launch_hold got %b exp 1", launch); end
    cyc(2);
    frame_clk = 1'b0;
    cyc(4);
    checks++; if ({phase, launch} !== {3'd2, 1'b0}) begin errors++;
      $display("FAIL flight_enter got phase %0d launch %b exp 2/0", phase, launch); end
  endtask

  task automatic test_hit_and_swap();
    tank1_x = 10'd500; tank1_y = 10'd305;
    bomb_x = 10'd510; bomb_y = 10'd300;
    exploded = 1'b1;
    cyc(1);
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL resolve_phase got %0d exp 3", phase); end
    cyc(1);
    checks++; if (phase !== 3'd4) begin errors++; $display("FAIL settle_phase got %0d exp 4", phase); end
    checks++; if ({health0, health1} !== {4'd3, 4'd2}) begin errors++;
      $display("FAIL hit_tank1 got %0d/%0d exp 3/2", health0, health1); end
    frame_pulse();
    checks++; if ({phase, active_player} !== {3'd4, 1'b0}) begin errors++;
      $display("FAIL settle_wait got phase %0d player %b exp 4/0", phase, active_player); end
    frame_pulse();
    checks++; if ({phase, active_player} !== {3'd0, 1'b1}) begin errors++;
      $display("FAIL turn_swap got phase %0d player %b exp 0/1", phase, active_player); end
    checks++; if ({angle, power} !== {4'd2, 3'd3}) begin errors++;
      $display("FAIL p1_regs got %0d/%0d exp 2/3", angle, power); end
  endtask

  task automatic test_timeout();
    exploded = 1'b0;
    bomb_x = 10'd500; bomb_y = 10'd305;
    press(5'b10000);
    frame_pulse();
    repeat (599) frame_pulse();
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL timeout_early got %0d exp 2", phase); end
    frame_pulse();
    checks++; if (phase !== 3'd4) begin errors++; $display("FAIL timeout_forced got %0d exp 4", phase); end
    checks++; if ({health0, health1} !== {4'd3, 4'd2}) begin errors++;
      $display("FAIL timeout_nodmg got %0d/%0d exp 3/2", health0, health1); end
    frame_pulse();
    frame_pulse();
    checks++; if ({phase, active_player} !== {3'd0, 1'b0}) begin errors++;
      $display("FAIL timeout_swap got phase %0d player %b exp 0/0", phase, active_player); end
  endtask

  task automatic test_self_and_boundary();
    tank1_x = 10'd300; tank1_y = 10'd305;
    fire_and_detonate(10'd100, 10'd310);
    checks++; if ({health0, health1, active_player} !== {4'd2, 4'd2, 1'b1}) begin errors++;
      $display("FAIL self_hit got %0d/%0d p%b exp 2/2 p1", health0, health1, active_player); end
    fire_and_detonate(10'd114, 10'd300);
    checks++; if ({health0, health1, active_player} !== {4'd1, 4'd2, 1'b0}) begin errors++;
      $display("FAIL edge_hit got %0d/%0d p%b exp 1/2 p0", health0, health1, active_player); end
    fire_and_detonate(10'd314, 10'd306);
    checks++; if ({health0, health1, active_player} !== {4'd1, 4'd2, 1'b1}) begin errors++;
      $display("FAIL edge_miss got %0d/%0d p%b exp 1/2 p1", health0, health1, active_player); end
  endtask

  task automatic test_game_over();
    fire_and_detonate(10'd300, 10'd305);
    checks++; if ({health0, health1, active_player} !== {4'd1, 4'd1, 1'b0}) begin errors++;
      $display("FAIL p1_self got %0d/%0d p%b exp 1/1 p0", health0, health1, active_player); end
    fire_and_detonate(10'd300, 10'd305);
    checks++; if ({phase, game_over, winner} !== {3'd5, 1'b1, 1'b0}) begin errors++;
      $display("FAIL game_over got phase %0d go %b win %b exp 5/1/0", phase, game_over, winner); end
    press(5'b10000);
    checks++; if ({phase, game_over, active_player} !== {3'd0, 1'b0, 1'b0}) begin errors++;
      $display("FAIL restart got phase %0d go %b p%b exp 0/0/0", phase, game_over, active_player); end
    checks++; if ({health0, health1, angle, power} !== {4'd3, 4'd3, 4'd6, 3'd3}) begin errors++;
      $display("FAIL restart_regs got %0d/%0d a%0d p%0d exp 3/3 a6 p3",
               health0, health1, angle, power); end
  endtask

  task automatic test_back_to_back();
    exploded = 1'b0;
    press(5'b10010);
    checks++; if ({phase, power} !== {3'd1, 3'd3}) begin errors++;
      $display("FAIL fire_wins got phase %0d power %0d exp 1/3", phase, power); end
    frame_pulse();
    checks++; if (phase !== 3'd2) begin errors++; $display("FAIL reflight got %0d exp 2", phase); end
    reset = 1'b1;
    #1;
    checks++; if ({launch, phase} !== {1'b0, 3'd0}) begin errors++;
      $display("FAIL mid_reset got launch %b phase %0d exp 0/0", launch, phase); end
    cyc(2);
    reset = 1'b0;
    cyc(2);
  endtask

  initial begin
    reset = 1'b1;
    {frame_clk, fire_key, ang_up_key, ang_dn_key, pwr_up_key, pwr_dn_key} = 6'b0;
    tank0_x = 10'd100; tank0_y = 10'd300; tank1_x = 10'd500; tank1_y = 10'd305;
    bomb_x = 10'd0; bomb_y = 10'd0;
    exploded = 1'b1;
    test_reset();
    test_aim_adjust();
    test_launch();
    test_hit_and_swap();
    test_timeout();
    test_self_and_boundary();
    test_game_over();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
